// File: rtl/alu_pkg.sv
// Shared types for the add/subtract datapath: opcode encoding and flag bundle.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    // Carry injected into bit 0. Subtraction is A + ~B + 1, and a borrow-in
    // removes that +1, so the injected carry is the inverted borrow.
    function automatic logic eff_carry(op_t op, logic c_in);
        return (op == OP_SUB) ? ~c_in : c_in;
    endfunction

endpackage

// File: rtl/Full_Adder.sv
// Single-bit full adder cell, the leaf of every carry-chain slice.
// Latency: combinational.
// Backpressure: not applicable.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic p;

    // Propagate/generate form keeps the carry path to one AND-OR level.
    always_comb begin
        p     = a ^ b;
        sum   = p ^ c_in;
        c_out = (a & b) | (c_in & p);
    end

endmodule

// File: rtl/adder_slice.sv
// W-bit ripple-carry slice built from Full_Adder cells; one slice per pipe stage.
// Latency: combinational.
// Backpressure: not applicable.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    // carry[W] is the MSB of the W+1 bit slice sum and leaves as c_out.
    logic [W:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < W; i++) begin : g_bit
        Full_Adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (carry[i]),
            .sum  (sum[i]),
            .c_out(carry[i+1])
        );
    end

    assign c_out = carry[W];

endmodule

// File: rtl/pipelined_add_sub.sv
// N-bit add/subtract with the carry chain cut into STAGES registered slices; NZCV flags.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle throughput.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready that cycle.
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  op_t          op,
    input  logic         C_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         C_out,
    output logic         V,
    output logic         Z,
    output logic         Nf
);

    localparam int W  = N / STAGES;
    localparam int L  = STAGES - 1;
    // Number of inter-stage register banks; kept at least 1 so STAGES=1 still elaborates.
    localparam int PL = (STAGES > 1) ? STAGES - 1 : 1;

    if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_param_check
        $error("pipelined_add_sub: N (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= N",
               N, STAGES);
    end

    // Per-stage view of the operands entering each slice. Index k is what
    // slice k sees: stage 0 takes the ports, stage k>0 takes bank k-1.
    logic [STAGES-1:0][N-1:0] a_src;
    logic [STAGES-1:0][N-1:0] b_src;
    logic [STAGES-1:0][N-1:0] s_src;
    logic [STAGES-1:0][N-1:0] s_next;
    logic [STAGES-1:0]        c_src;
    logic [STAGES-1:0]        v_src;

    logic [STAGES-1:0][W-1:0] sl_sum;
    logic [STAGES-1:0]        sl_c;

    // Inter-stage banks: operands carried forward, partial sum, slice carry, valid.
    logic [PL-1:0][N-1:0] a_q;
    logic [PL-1:0][N-1:0] b_q;
    logic [PL-1:0][N-1:0] s_q;
    logic [PL-1:0]        c_q;
    logic [PL-1:0]        v_q;

    flags_t flags_d;
    flags_t flags_q;
    logic   stall;

    // A held output beat freezes the whole pipe; no bubble squeezing.
    always_comb begin
        stall    = out_valid && !out_ready;
        in_ready = !rst && !stall;
    end

    // Route each slice's inputs; B inversion and carry select happen only at stage 0.
    always_comb begin
        a_src    = '0;
        b_src    = '0;
        s_src    = '0;
        c_src    = '0;
        v_src    = '0;
        a_src[0] = A;
        b_src[0] = (op == OP_SUB) ? ~B : B;
        s_src[0] = '0;
        c_src[0] = eff_carry(op, C_in);
        v_src[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.W(W)) u_slice (
            .a    (a_src[k][k*W +: W]),
            .b    (b_src[k][k*W +: W]),
            .c_in (c_src[k]),
            .sum  (sl_sum[k]),
            .c_out(sl_c[k])
        );
    end

    // Merge each finished slice into the running sum; slices above k are still zero.
    always_comb begin
        s_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_next[k] = s_src[k] | (N'(sl_sum[k]) << (k * W));
        end
    end

    // Flags are formed from the completed sum in the last slice, before the output register.
    always_comb begin
        flags_d   = '0;
        flags_d.c = sl_c[L];
        flags_d.v = (a_src[L][N-1] == b_src[L][N-1]) && (s_next[L][N-1] != a_src[L][N-1]);
        flags_d.z = ~|s_next[L];
        flags_d.n = s_next[L][N-1];
    end

    // Stage registers: all advance together unless stalled; reset discards in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= '0;
            v_q       <= '0;
            out_valid <= 1'b0;
            S         <= '0;
            flags_q   <= '0;
        end else if (!stall) begin
            for (int k = 0; k < L; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_next[k];
                c_q[k] <= sl_c[k];
                v_q[k] <= v_src[k];
            end
            out_valid <= v_src[L];
            S         <= s_next[L];
            flags_q   <= flags_d;
        end
    end

    assign C_out = flags_q.c;
    assign V     = flags_q.v;
    assign Z     = flags_q.z;
    assign Nf    = flags_q.n;

    // Operand bits below the last slice are already consumed by the time they
    // reach it, and with STAGES=1 the inter-stage banks have no reader at all.
    logic unused_bits;
    assign unused_bits = ^{a_src[L], b_src[L], a_q, b_q, s_q, c_q, v_q};

endmodule
